// File: rtl/fifo_pkg.sv
// Types and defaults shared by the async FIFO and its read-side stream adapter.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_ONE   = 2'd1,
    RS_TWO   = 2'd2
  } rd_stream_state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: pops FWFT entries into a 2-entry buffer and
// presents them as valid/ready. Define FIFO_RD_STREAM_STATS_EN to add the out_count fire counter.
//
// state    | meaning
// RS_EMPTY | buffer holds no entry, out_valid low
// RS_ONE   | head register valid
// RS_TWO   | head and tail valid, no further pops
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_empty,
  input  logic [DSIZE-1:0] rd_data,
  output logic             rd_inc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [15:0]      out_count,
`endif
  output logic [DSIZE-1:0] out_data
);

  rd_stream_state_e state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic             fire;

  // Pop decision never looks at out_ready, keeping the downstream path registered.
  assign rd_inc    = !rd_empty && (state_q != RS_TWO) && !flush && rd_rst;
  assign out_valid = (state_q != RS_EMPTY);
  assign out_data  = head_q;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      RS_EMPTY: begin
        if (rd_inc) begin
          state_d = RS_ONE;
          head_d  = rd_data;
        end
      end
      RS_ONE: begin
        if (rd_inc && fire) begin
          head_d = rd_data;
        end else if (rd_inc) begin
          state_d = RS_TWO;
          tail_d  = rd_data;
        end else if (fire) begin
          state_d = RS_EMPTY;
        end
      end
      RS_TWO: begin
        if (fire) begin
          state_d = RS_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = RS_EMPTY;
    endcase
    if (flush) state_d = RS_EMPTY;
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      state_q <= RS_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] count_q, count_d;

  assign count_d   = count_q + {15'd0, fire};
  assign out_count = count_q;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) count_q <= '0;
    else         count_q <= count_d;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized scoreboard bench for fifo_rd_stream: a queue-based FIFO feeds the DUT and a
// queue of buffered entries predicts what the stream must deliver.
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;

  logic             clk = 1'b0;
  logic             rd_rst = 1'b0;
  logic             rd_empty = 1'b1;
  logic [DSIZE-1:0] rd_data = '0;
  logic             rd_inc;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DSIZE-1:0] out_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0]      out_count;
`endif

  fifo_rd_stream #(.DSIZE(DSIZE)) dut (
    .rd_clk   (clk),
    .rd_rst   (rd_rst),
    .rd_empty (rd_empty),
    .rd_data  (rd_data),
    .rd_inc   (rd_inc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FIFO_RD_STREAM_STATS_EN
    .out_count(out_count),
`endif
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  logic [DSIZE-1:0] mq[$];   // entries still inside the FIFO
  logic [DSIZE-1:0] sb[$];   // entries held by the stream buffer, oldest first
  int n_tests = 0;
  int n_fail  = 0;
  int n_fire  = 0;
  bit rst_done = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every valid cycle the head must match the oldest buffered entry; a fire retires it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data", 32'(out_data), 32'(sb[0]));
          if (out_ready) begin
            void'(sb.pop_front());
            n_fire++;
          end
        end
      end
    end
  end

  // One read-clock cycle: drive at negedge, predict pop and occupancy, then apply flush/reset.
  task automatic cyc(input bit bub, input bit rdy, input bit fl, input bit rst);
    int  occ;
    bit  exp_inc;
    @(negedge clk);
    rd_rst    = rst;
    flush     = fl;
    out_ready = rdy;
    rd_empty  = bub || (mq.size() == 0);
    rd_data   = (mq.size() != 0) ? mq[0] : DSIZE'($urandom);
    #2;
    occ     = sb.size();
    exp_inc = !rd_empty && (occ < 2) && !fl && rst;
    check("rd_inc", 32'(rd_inc), 32'(exp_inc));
    if (rst_done) check("out_valid", 32'(out_valid), 32'(occ != 0));
    if (exp_inc) sb.push_back(mq.pop_front());
    #2;
    if (!rst || fl) sb.delete();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || mq.size() != 0) && k < budget) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      k++;
    end
    check("drain_done", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int f0, pushed;
    logic [15:0] cnt0;

    // Reset held 3 cycles with the FIFO non-empty.
    for (int i = 1; i <= 16; i++) mq.push_back(DSIZE'(i));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      rst_done = 1'b1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
    end

    // Streaming: first entry visible the cycle after its pop, then one per cycle.
    f0 = n_fire;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("first_lat_nv", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("first_lat_v", 32'(out_valid), 32'd1);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("stream_cnt", 32'(n_fire - f0), 32'd16);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // Back-pressure: only two entries prefetched, head held.
    for (int i = 0; i < 5; i++) mq.push_back(DSIZE'(8'hA0 + i));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_remaining", 32'(mq.size()), 32'd3);
    check("bp_head", 32'(out_data), 32'hA0);
    f0 = n_fire;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("bp_no_gaps", 32'(n_fire - f0), 32'd5);
    drain(10);

    // Flush while full: 0x33 must come out two cycles after the flush.
    mq.push_back(8'h11); mq.push_back(8'h22); mq.push_back(8'h33);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_valid", 32'(out_valid), 32'd1);
`ifdef FIFO_RD_STREAM_STATS_EN
    cnt0 = out_count;
`else
    cnt0 = 16'd0;
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_flush_head", 32'(out_data), 32'h33);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("flush_keeps_count", 32'(out_count), 32'(cnt0));
`endif
    drain(10);

    // Bubbles: rd_empty forced every other cycle, random readiness and refills.
    f0 = n_fire;
    pushed = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        mq.push_back(DSIZE'($urandom));
        pushed++;
      end
      cyc(1'(i % 2), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    drain(1000);
    check("bubble_all_delivered", 32'(n_fire - f0), 32'(pushed));

`ifdef FIFO_RD_STREAM_STATS_EN
    cnt0 = out_count;
    check("count_tracks_fires", 32'(cnt0), 32'(n_fire[15:0]));
    for (int i = 0; i < 65537; i++) mq.push_back(DSIZE'(i));
    drain(70000);
    check("count_wrap", 32'(out_count), 32'(16'(cnt0 + 16'd1)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
